// File: rtl/sr_cmd_debounce_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : sr_cmd_debounce_driver_if
// Brief   : Raw request inputs and S/R drive outputs of the SR command driver.
// Revision: 1.0
// ============================================================================
interface sr_cmd_debounce_driver_if;
   logic set_raw;
   logic rst_raw;
   logic S;
   logic R;
   logic busy;
   logic conflict;

   modport master (
      output set_raw,
      output rst_raw,
      input  S,
      input  R,
      input  busy,
      input  conflict
   );

   modport slave (
      input  set_raw,
      input  rst_raw,
      output S,
      output R,
      output busy,
      output conflict
   );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_debounce_driver.sv
`default_nettype none
// ============================================================================
// Module  : sr_cmd_debounce_driver
// Brief   : Synchronise, debounce and edge-detect two raw request lines and
//           issue arbitrated, never-overlapping S/R pulses to an SR flip-flop.
//           Optional macro SR_DRV_CONFLICT_CNT_EN adds a saturating
//           conflict_cnt[7:0] output.
// Revision: 1.0
// ============================================================================
module sr_cmd_debounce_driver #(
   parameter int DB_CYCLES      = 16,
   parameter int PULSE_CYCLES   = 1,
   parameter int HOLDOFF_CYCLES = 4,
   parameter int PRIORITY       = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   sr_cmd_debounce_driver_if.slave  sr_if
`ifdef SR_DRV_CONFLICT_CNT_EN
   ,
   output logic [7:0]               conflict_cnt
`endif
);

   localparam int C_DB_W    = $clog2(DB_CYCLES + 1);
   localparam int C_TMR_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int C_TMR_W   = $clog2(C_TMR_MAX + 1);
   localparam int C_HOLD_M1 = (HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0;

   localparam logic [C_DB_W-1:0]  C_DB_LAST    = C_DB_W'(DB_CYCLES - 1);
   localparam logic [C_TMR_W-1:0] C_PULSE_LAST = C_TMR_W'(PULSE_CYCLES - 1);
   localparam logic [C_TMR_W-1:0] C_HOLD_LAST  = C_TMR_W'(C_HOLD_M1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   // Bit 0 = set line, bit 1 = reset line.
   logic [1:0] w_raw;
   logic [1:0] w_edge;
   logic [1:0] pend_d;

   state_t               state_q;
   logic [1:0]           pend_q;
   logic [C_TMR_W-1:0]   tmr_q;
   logic                 s_q;
   logic                 r_q;
   logic                 conflict_q;
`ifdef SR_DRV_CONFLICT_CNT_EN
   logic [7:0]           conflict_cnt_q;
`endif

   assign w_raw = {sr_if.rst_raw, sr_if.set_raw};

   for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic              sync1_q;
      logic              sync2_q;
      logic              db_q;
      logic              db_dly_q;
      logic [C_DB_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            sync1_q  <= w_raw[gi];
            sync2_q  <= sync1_q;
            db_dly_q <= db_q;
            if (sync2_q == db_q) begin
               cnt_q <= '0;
            end else if (cnt_q == C_DB_LAST) begin
               db_q  <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + C_DB_W'(1);
            end
         end
      end

      assign w_edge[gi] = db_q & ~db_dly_q;
   end

   // IDLE consumes every pending request: issued, lost in arbitration, or dropped.
   assign pend_d = ((state_q == ST_IDLE) ? 2'b00 : pend_q) | w_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         pend_q         <= 2'b00;
         tmr_q          <= '0;
         s_q            <= 1'b0;
         r_q            <= 1'b0;
         conflict_q     <= 1'b0;
`ifdef SR_DRV_CONFLICT_CNT_EN
         conflict_cnt_q <= 8'h00;
`endif
      end else begin
         pend_q     <= pend_d;
         conflict_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tmr_q <= '0;
               if (pend_q == 2'b11) begin
                  conflict_q <= 1'b1;
`ifdef SR_DRV_CONFLICT_CNT_EN
                  if (conflict_cnt_q != 8'hFF) begin
                     conflict_cnt_q <= conflict_cnt_q + 8'h01;
                  end
`endif
                  if (PRIORITY == 0) begin
                     r_q     <= 1'b1;
                     state_q <= ST_PULSE;
                  end else if (PRIORITY == 1) begin
                     s_q     <= 1'b1;
                     state_q <= ST_PULSE;
                  end
               end else if (pend_q[0]) begin
                  s_q     <= 1'b1;
                  state_q <= ST_PULSE;
               end else if (pend_q[1]) begin
                  r_q     <= 1'b1;
                  state_q <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (tmr_q == C_PULSE_LAST) begin
                  s_q   <= 1'b0;
                  r_q   <= 1'b0;
                  tmr_q <= '0;
                  if (HOLDOFF_CYCLES == 0) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_HOLDOFF;
                  end
               end else begin
                  tmr_q <= tmr_q + C_TMR_W'(1);
               end
            end
            ST_HOLDOFF: begin
               if (tmr_q == C_HOLD_LAST) begin
                  tmr_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + C_TMR_W'(1);
               end
            end
            default: begin
               s_q     <= 1'b0;
               r_q     <= 1'b0;
               tmr_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sr_if.S        = s_q;
   assign sr_if.R        = r_q;
   assign sr_if.busy     = (state_q != ST_IDLE);
   assign sr_if.conflict = conflict_q;
`ifdef SR_DRV_CONFLICT_CNT_EN
   assign conflict_cnt   = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_debounce_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_sr_cmd_debounce_driver
// Brief   : Directed bench; three instances differing only in PRIORITY share
//           the same raw request stimulus.
// Revision: 1.0
// ============================================================================
module tb_sr_cmd_debounce_driver;

   localparam int DB = 4;
   localparam int PL = 1;
   localparam int HO = 3;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic set_raw = 1'b0;
   logic rst_raw = 1'b0;
   logic both_seen = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_a, cnt_b, cnt_c;

   always #5 clk = ~clk;

   sr_cmd_debounce_driver_if if0 ();
   sr_cmd_debounce_driver_if if1 ();
   sr_cmd_debounce_driver_if if2 ();

   assign if0.set_raw = set_raw;
   assign if0.rst_raw = rst_raw;
   assign if1.set_raw = set_raw;
   assign if1.rst_raw = rst_raw;
   assign if2.set_raw = set_raw;
   assign if2.rst_raw = rst_raw;

`ifdef SR_DRV_CONFLICT_CNT_EN
   logic [7:0] cc0, cc1, cc2;
`endif

   sr_cmd_debounce_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(PL), .HOLDOFF_CYCLES(HO), .PRIORITY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .sr_if(if0)
`ifdef SR_DRV_CONFLICT_CNT_EN
      , .conflict_cnt(cc0)
`endif
   );

   sr_cmd_debounce_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(PL), .HOLDOFF_CYCLES(HO), .PRIORITY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sr_if(if1)
`ifdef SR_DRV_CONFLICT_CNT_EN
      , .conflict_cnt(cc1)
`endif
   );

   sr_cmd_debounce_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(PL), .HOLDOFF_CYCLES(HO), .PRIORITY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .sr_if(if2)
`ifdef SR_DRV_CONFLICT_CNT_EN
      , .conflict_cnt(cc2)
`endif
   );

   always @(negedge clk) begin
      if ((if0.S && if0.R) || (if1.S && if1.R) || (if2.S && if2.R)) both_seen = 1'b1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lets both lines settle low and any holdoff expire between scenarios.
   task automatic idle_gap();
      set_raw = 1'b0;
      rst_raw = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_S", int'(if0.S), 0);
      check("rst_R", int'(if0.R), 0);
      check("rst_busy", int'(if0.busy), 0);
      check("rst_conflict", int'(if0.conflict), 0);
`ifdef SR_DRV_CONFLICT_CNT_EN
      check("rst_cnt", int'(cc0), 0);
`endif
      rst_n = 1'b1;
      tick();

      // Single set request: S at cycle 4+DB, busy PL+HO cycles
      set_raw = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 7) check("t1_S_c7", int'(if0.S), 0);
         if (k == 8) check("t1_S_c8", int'(if0.S), 1);
         if (k == 9) check("t1_S_c9", int'(if0.S), 0);
         cnt_a += int'(if0.busy);
         cnt_b += int'(if0.R);
      end
      check("t1_busy_cycles", cnt_a, 4);
      check("t1_R_never", cnt_b, 0);
      set_raw = 1'b0;
      cnt_a = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         cnt_a += int'(if0.S);
      end
      check("t1_fall_no_S", cnt_a, 0);

      // Glitch of DB-1 cycles is rejected
      rst_raw = 1'b1;
      repeat (3) tick();
      rst_raw = 1'b0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         cnt_a += int'(if0.R);
         cnt_b += int'(if0.conflict);
         cnt_c += int'(if0.busy);
      end
      check("t2_glitch_R", cnt_a, 0);
      check("t2_glitch_conflict", cnt_b, 0);
      check("t2_glitch_busy", cnt_c, 0);

      // Simultaneous requests: arbitration per PRIORITY
      set_raw = 1'b1;
      rst_raw = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 8) begin
            check("t3_p0_conflict", int'(if0.conflict), 1);
            check("t3_p0_R", int'(if0.R), 1);
            check("t3_p0_S", int'(if0.S), 0);
            check("t3_p1_conflict", int'(if1.conflict), 1);
            check("t3_p1_S", int'(if1.S), 1);
            check("t3_p1_R", int'(if1.R), 0);
            check("t3_p2_conflict", int'(if2.conflict), 1);
            check("t3_p2_SR", int'({if2.S, if2.R}), 0);
         end
         if (k == 9) check("t3_p0_conflict_c9", int'(if0.conflict), 0);
         cnt_a += int'(if2.busy);
         cnt_b += int'(if0.S);
      end
      check("t3_p2_busy", cnt_a, 0);
      check("t3_p0_S_never", cnt_b, 0);
`ifdef SR_DRV_CONFLICT_CNT_EN
      check("t3_cnt_one", int'(cc0), 1);
`endif
      idle_gap();

      // Reset request accepted during HOLDOFF is served after returning to IDLE
      set_raw = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k == 3) rst_raw = 1'b1;
         if (k == 8) check("t4_S_c8", int'(if0.S), 1);
         if (k == 10) check("t4_R_holdoff", int'(if0.R), 0);
         if (k == 12) begin
            check("t4_busy_c12", int'(if0.busy), 0);
            check("t4_R_c12", int'(if0.R), 0);
         end
         if (k == 13) check("t4_R_c13", int'(if0.R), 1);
         if (k == 14) check("t4_R_c14", int'(if0.R), 0);
      end
      idle_gap();

      // Asynchronous reset truncates a live pulse
      set_raw = 1'b1;
      for (int k = 1; k <= 8; k++) tick();
      check("t5_S_before", int'(if0.S), 1);
      rst_n   = 1'b0;
      set_raw = 1'b0;
      #1;
      check("t5_S_async", int'(if0.S), 0);
      check("t5_busy_async", int'(if0.busy), 0);
      tick();
      tick();
      rst_n = 1'b1;
      cnt_a = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         cnt_a += int'(if0.S) + int'(if0.R) + int'(if0.busy);
      end
      check("t5_quiet_after", cnt_a, 0);
      set_raw = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 7) check("t5_fresh_c7", int'(if0.S), 0);
         if (k == 8) check("t5_fresh_c8", int'(if0.S), 1);
      end
      idle_gap();

`ifdef SR_DRV_CONFLICT_CNT_EN
      // Counter saturation under repeated conflicts
      for (int n = 0; n < 300; n++) begin
         set_raw = 1'b1;
         rst_raw = 1'b1;
         repeat (14) tick();
         set_raw = 1'b0;
         rst_raw = 1'b0;
         repeat (10) tick();
      end
      check("t6_cnt_sat_p0", int'(cc0), 255);
      check("t6_cnt_sat_p1", int'(cc1), 255);
      check("t6_cnt_sat_p2", int'(cc2), 255);
      rst_n = 1'b0;
      #1;
      check("t6_cnt_rst", int'(cc0), 0);
      tick();
      rst_n = 1'b1;
      tick();
`endif

      check("s_and_r_never", int'(both_seen), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
